cache_control: RTL and testbench
================================

# cache_control

Controller FSM for the 2-way, 8-set cache: it decides hit or miss from tag-match and valid bits, and sequences writeback and fill over the physical-memory handshake. It drives the load strobes of the valid, tag and data arrays. It owns per-set LRU bits and per-line dirty bits; the valid, tag and data arrays stay external. It sits between the CPU memory port and physical memory, alongside the cache datapath.

## Interface
- NUM_SETS, 8, number of sets; the set index is log2(NUM_SETS) = 3 bits
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- set_idx  in  3  set index of the current request
- tag_match0  in  1  way0 stored tag equals request tag (raw compare, not qualified by valid)
- tag_match1  in  1  way1 stored tag equals request tag (raw compare, not qualified by valid)
- v0  in  1  valid bit of way0 at set_idx, from the valid array
- v1  in  1  valid bit of way1 at set_idx, from the valid array
- pmem_resp  in  1  physical memory done; one-cycle pulse
- mem_resp  out  1  CPU request complete; one-cycle pulse
- pmem_read  out  1  line fill request to physical memory
- pmem_write  out  1  line writeback request to physical memory
- way_sel  out  1  way addressed by array loads and reads
- valid_load  out  1  valid array load strobe
- tag_load  out  1  tag array load strobe
- data_load  out  1  data array load strobe
- data_src_sel  out  1  data array write source: 0 = CPU write data, 1 = pmem line
- pmem_addr_sel  out  1  pmem address source: 0 = request tag+set, 1 = victim stored tag+set

## Operation
- States: COMPARE (reset state), WRITEBACK, FILL. Outputs are combinational from state and inputs. Every output not listed as asserted in a state is 0.
- Internal hit terms: hit0 = tag_match0 & v0; hit1 = tag_match1 & v1; hit = hit0 | hit1. way_sel follows the hit way; hit0 wins if both are set.
- COMPARE, no request: stay; all outputs 0.
- COMPARE, read hit: mem_resp = 1 the same cycle; lru[set_idx] <= non-hit way.
- COMPARE, write hit:
  - data_load = 1, data_src_sel = 0, way_sel = hit way, mem_resp = 1.
  - dirty[set_idx][way] <= 1; lru[set_idx] <= non-hit way.
- mem_read and mem_write both high: treated as a write.
- COMPARE, miss:
  - Victim is chosen as: way0 if !v0; else way1 if !v1; else lru[set_idx]. The victim is registered.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to FILL. No mem_resp on the miss cycle.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1, way_sel = victim.
  - On pmem_resp: dirty[set][victim] <= 0, go to FILL.
- FILL:
  - pmem_read = 1, pmem_addr_sel = 0, way_sel = victim.
  - On pmem_resp: data_load = tag_load = valid_load = 1, data_src_sel = 1, dirty[set][victim] <= 0, go to COMPARE.
  - The request then re-evaluates as a hit on the next cycle, which performs the LRU update, the write merge and mem_resp.
- pmem_resp in COMPARE is ignored.
- A CPU request dropped during WRITEBACK/FILL does not abort the memory handshake. The transaction completes, then the FSM returns to COMPARE idle.
- Reset values: state = COMPARE; all lru = 0; all dirty = 0; victim = 0; all outputs 0.
- Reset mid-WRITEBACK/FILL: pmem_read/pmem_write drop immediately (asynchronous reset). The valid array is not cleared by this block; its reinitialisation is system-level.

## Timing
- Read/write hit latency: 0 cycles; mem_resp is in the request's first COMPARE cycle.
- Clean miss: 1 COMPARE cycle + FILL cycles until pmem_resp + 1 COMPARE hit cycle.
- Dirty miss adds the WRITEBACK cycles until pmem_resp.
- pmem_read/pmem_write stay asserted continuously until the cycle pmem_resp is sampled high. They deassert in the cycle after that.
- The FSM never asserts pmem_read and pmem_write together.
- LRU and dirty updates take effect at the edge ending the qualifying cycle.
- Set index and victim are stable from the miss cycle through the end of the fill.

## Test plan
- After reset, read set 3 with v0 = v1 = 0 → FILL with way_sel = 0 and pmem_read = 1. Respond with pmem_resp after 4 cycles → one-cycle valid_load/tag_load/data_load on way0. Next cycle hit0 gives mem_resp = 1 and lru[3] = 1.
- Write hit way1 in set 5 → same-cycle data_load = 1, data_src_sel = 0, way_sel = 1, mem_resp = 1. Then dirty[5][1] = 1 and lru[5] = 0.
- Set 5 with both ways valid, lru = 1 and way1 dirty, then read miss → WRITEBACK with pmem_write = 1, pmem_addr_sel = 1, way_sel = 1. On pmem_resp go to FILL; after the fill, dirty[5][1] = 0.
- Read miss with v0 = 1 and v1 = 0 and lru = 0 → victim is way1 (the invalid way beats LRU).
- Assert reset two cycles into FILL → pmem_read = 0 immediately; state COMPARE, lru and dirty all 0.
- Drop mem_read during FILL → pmem_read is held until pmem_resp. Fill loads complete, no mem_resp is issued, and the FSM returns to COMPARE idle.

Source files
------------

// File: rtl/cache_control_if.sv
// cache_control_if: CPU request, tag/valid lookup, pmem handshake and array load strobes
interface cache_control_if #(parameter int NUM_SETS = 8);
  logic                        mem_read;
  logic                        mem_write;
  logic [$clog2(NUM_SETS)-1:0] set_idx;
  logic                        tag_match0;
  logic                        tag_match1;
  logic                        v0;
  logic                        v1;
  logic                        pmem_resp;
  logic                        mem_resp;
  logic                        pmem_read;
  logic                        pmem_write;
  logic                        way_sel;
  logic                        valid_load;
  logic                        tag_load;
  logic                        data_load;
  logic                        data_src_sel;
  logic                        pmem_addr_sel;
  modport master (
    output mem_read, mem_write, set_idx, tag_match0, tag_match1, v0, v1, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, way_sel, valid_load, tag_load, data_load,
           data_src_sel, pmem_addr_sel
  );
  modport slave (
    input  mem_read, mem_write, set_idx, tag_match0, tag_match1, v0, v1, pmem_resp,
    output mem_resp, pmem_read, pmem_write, way_sel, valid_load, tag_load, data_load,
           data_src_sel, pmem_addr_sel
  );
endinterface

// File: rtl/cache_control.sv
// cache_control: 2-way cache controller FSM with per-set LRU and per-line dirty bits
module cache_control #(parameter int NUM_SETS = 8) (
  input  logic            clk,
  input  logic            reset,
  cache_control_if.slave  bus
);
  typedef enum logic [1:0] {COMPARE, WRITEBACK, FILL} state_t;
  state_t                       state_q, state_d;
  logic [NUM_SETS-1:0]          lru_q, lru_d;
  logic [NUM_SETS-1:0][1:0]     dirty_q, dirty_d;
  logic                         victim_q, victim_d;
  logic                         hit0, hit1, hit_way, victim_new;
  always_comb begin
    hit0       = bus.tag_match0 & bus.v0;
    hit1       = bus.tag_match1 & bus.v1;
    hit_way    = !hit0;
    victim_new = !bus.v0 ? 1'b0 : !bus.v1 ? 1'b1 : lru_q[bus.set_idx];
    state_d    = state_q;
    lru_d      = lru_q;
    dirty_d    = dirty_q;
    victim_d   = victim_q;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.way_sel       = 1'b0;
    bus.valid_load    = 1'b0;
    bus.tag_load      = 1'b0;
    bus.data_load     = 1'b0;
    bus.data_src_sel  = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    case (state_q)
      COMPARE: if (bus.mem_read || bus.mem_write) begin
        if (hit0 || hit1) begin
          bus.mem_resp           = 1'b1;
          bus.way_sel            = hit_way;
          bus.data_load          = bus.mem_write;
          lru_d[bus.set_idx]     = !hit_way;
          if (bus.mem_write) dirty_d[bus.set_idx][hit_way] = 1'b1;
        end else begin
          // a victim can only be dirty when both ways are valid
          victim_d = victim_new;
          state_d  = (bus.v0 && bus.v1 && dirty_q[bus.set_idx][victim_new]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.way_sel       = victim_q;
        if (bus.pmem_resp) begin
          dirty_d[bus.set_idx][victim_q] = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim_q;
        if (bus.pmem_resp) begin
          bus.data_load    = 1'b1;
          bus.tag_load     = 1'b1;
          bus.valid_load   = 1'b1;
          bus.data_src_sel = 1'b1;
          dirty_d[bus.set_idx][victim_q] = 1'b0;
          state_d = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= COMPARE;
      lru_q    <= '0;
      dirty_q  <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lru_q    <= lru_d;
      dirty_q  <= dirty_d;
      victim_q <= victim_d;
    end
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed vectors against hand-computed controller outputs and LRU/dirty state
module tb_cache_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  logic [8:0] o;
  cache_control_if #(.NUM_SETS(8)) bus ();
  cache_control #(.NUM_SETS(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // {mem_resp, pmem_read, pmem_write, way_sel, valid_load, tag_load, data_load, data_src_sel, pmem_addr_sel}
  assign o = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.way_sel, bus.valid_load,
              bus.tag_load, bus.data_load, bus.data_src_sel, bus.pmem_addr_sel};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic rd, input logic wr, input logic [2:0] s, input logic t0,
                     input logic t1, input logic a, input logic b);
    bus.mem_read = rd; bus.mem_write = wr; bus.set_idx = s;
    bus.tag_match0 = t0; bus.tag_match1 = t1; bus.v0 = a; bus.v1 = b;
  endtask
  initial begin
    req(0, 0, 0, 0, 0, 0, 0);
    bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", o, 9'b0);
    chk("rst_lru", dut.lru_q, 0);
    chk("rst_dirty", dut.dirty_q, 0);
    reset = 1'b0;
    tick();
    bus.pmem_resp = 1'b1;
    #1 chk("idle_presp_out", o, 9'b0);
    tick();
    bus.pmem_resp = 1'b0;
    #1 chk("idle_presp_state", dut.state_q, 0);
    req(1, 0, 3, 0, 0, 0, 0);
    #1 chk("miss3_out", o, 9'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill3_out", o, 9'b0_1_0_0_0_0_0_0_0);
    end
    bus.pmem_resp = 1'b1;
    #1 chk("fill3_resp", o, 9'b0_1_0_0_1_1_1_1_0);
    tick();
    bus.pmem_resp = 1'b0;
    req(1, 0, 3, 1, 0, 1, 0);
    #1 chk("hit3_out", o, 9'b1_0_0_0_0_0_0_0_0);
    tick();
    req(0, 0, 3, 0, 0, 0, 0);
    #1 chk("lru3", dut.lru_q[3], 1);
    chk("dirty3", dut.dirty_q[3], 0);
    req(1, 1, 5, 0, 1, 1, 1);
    #1 chk("whit5_out", o, 9'b1_0_0_1_0_0_1_0_0);
    tick();
    req(1, 0, 5, 1, 0, 1, 1);
    #1 chk("dirty5_w1", dut.dirty_q[5], 2'b10);
    chk("lru5_w1", dut.lru_q[5], 0);
    chk("rhit5_out", o, 9'b1_0_0_0_0_0_0_0_0);
    tick();
    req(1, 0, 5, 0, 0, 1, 1);
    #1 chk("lru5_r0", dut.lru_q[5], 1);
    chk("miss5_out", o, 9'b0);
    tick();
    chk("wb5_out", o, 9'b0_0_1_1_0_0_0_0_1);
    tick();
    chk("wb5_hold", o, 9'b0_0_1_1_0_0_0_0_1);
    bus.pmem_resp = 1'b1;
    #1 chk("wb5_resp", o, 9'b0_0_1_1_0_0_0_0_1);
    tick();
    bus.pmem_resp = 1'b0;
    #1 chk("wb5_dirty", dut.dirty_q[5], 0);
    chk("fill5_out", o, 9'b0_1_0_1_0_0_0_0_0);
    bus.pmem_resp = 1'b1;
    #1 chk("fill5_resp", o, 9'b0_1_0_1_1_1_1_1_0);
    tick();
    bus.pmem_resp = 1'b0;
    req(1, 0, 5, 0, 1, 1, 1);
    #1 chk("hit5_after", o, 9'b1_0_0_1_0_0_0_0_0);
    tick();
    req(1, 0, 2, 0, 0, 1, 0);
    #1 chk("lru5_end", dut.lru_q[5], 0);
    chk("dirty5_end", dut.dirty_q[5], 0);
    chk("lru2_pre", dut.lru_q[2], 0);
    tick();
    chk("fill2_victim1", o, 9'b0_1_0_1_0_0_0_0_0);
    req(0, 0, 2, 0, 0, 1, 0);
    tick();
    chk("fill2_drop_hold", o, 9'b0_1_0_1_0_0_0_0_0);
    bus.pmem_resp = 1'b1;
    #1 chk("fill2_drop_resp", o, 9'b0_1_0_1_1_1_1_1_0);
    tick();
    bus.pmem_resp = 1'b0;
    #1 chk("drop_idle_out", o, 9'b0);
    tick();
    chk("drop_idle_state", dut.state_q, 0);
    chk("drop_idle_out2", o, 9'b0);
    req(0, 1, 5, 1, 0, 1, 1);
    #1 chk("whit5w0_out", o, 9'b1_0_0_0_0_0_1_0_0);
    tick();
    req(1, 0, 6, 0, 0, 0, 0);
    #1 chk("dirty5_w0", dut.dirty_q[5], 2'b01);
    tick();
    tick();
    chk("fill6_pre_rst", o, 9'b0_1_0_0_0_0_0_0_0);
    reset = 1'b1;
    #1 chk("rst_fill_out", o, 9'b0);
    chk("rst_fill_state", dut.state_q, 0);
    chk("rst_fill_lru", dut.lru_q, 0);
    chk("rst_fill_dirty", dut.dirty_q, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
